// File: rtl/rc5_decipher_seq_if.sv
// Bus between the RC5 decipher round sequencer and its wrapper: start/ciphertext in,
// S RAM read port, plaintext and status out.
interface rc5_decipher_seq_if #(
    parameter int W     = 32,
    parameter int T_LEN = 5
);
    logic             start;
    logic             key_ready;
    logic [W-1:0]     ct_a;
    logic [W-1:0]     ct_b;
    logic             s_rd;
    logic [T_LEN-1:0] s_addr;
    logic [W-1:0]     s_data;
    logic [W-1:0]     pt_a;
    logic [W-1:0]     pt_b;
    logic             busy;
    logic             done;

    // Wrapper side: owns the request, the ciphertext and the S RAM read data.
    modport master (
        output start, key_ready, ct_a, ct_b, s_data,
        input  s_rd, s_addr, pt_a, pt_b, busy, done
    );

    modport slave (
        input  start, key_ready, ct_a, ct_b, s_data,
        output s_rd, s_addr, pt_a, pt_b, busy, done
    );
endinterface

// File: rtl/rc5_decipher_seq.sv
// RC5-W/R decryption round sequencer: walks S[2R+1]..S[0] through a synchronous
// read port and applies the inverse rounds to the latched ciphertext pair.
module rc5_decipher_seq #(
    parameter int W       = 32,
    parameter int R       = 12,
    parameter int T_LEN   = $clog2(2*(R+1)),
    parameter int ROT_LEN = $clog2(W)
) (
    input  logic               clk,
    input  logic               rst,
    rc5_decipher_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PRIME, EVEN, ODD, FIN_B, FIN_A, DONE} state_t;

    localparam logic [T_LEN-1:0] TOP_ADDR = T_LEN'(2*R + 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [T_LEN-1:0] i;
    logic [T_LEN-1:0] addr_even;
    logic [W-1:0]     b_even;
    logic [W-1:0]     a_odd;
    logic             accept;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [ROT_LEN-1:0] n);
        logic [ROT_LEN-1:0] m;
        m = -n;  // left shift by W-n modulo W; n==0 gives x | x
        return (x >> n) | (x << m);
    endfunction

    assign accept    = (state == IDLE) && bus.start && bus.key_ready;
    assign addr_even = {i[T_LEN-2:0], 1'b0};
    assign b_even    = rotr(b - bus.s_data, a[ROT_LEN-1:0]) ^ a;
    assign a_odd     = rotr(a - bus.s_data, b[ROT_LEN-1:0]) ^ b;

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        bus.s_rd   = 1'b0;
        bus.s_addr = '0;
        unique case (state)
            IDLE:  if (accept) state_nxt = PRIME;
            PRIME: begin
                bus.s_rd   = 1'b1;
                bus.s_addr = TOP_ADDR;
                state_nxt  = EVEN;
            end
            EVEN: begin
                bus.s_rd   = 1'b1;
                bus.s_addr = addr_even;
                state_nxt  = ODD;
            end
            ODD: begin
                // Prefetch S[2(i-1)+1]; with i==1 that is S[1] for the final B subtraction.
                bus.s_rd   = 1'b1;
                bus.s_addr = addr_even - T_LEN'(1);
                state_nxt  = (i == T_LEN'(1)) ? FIN_B : EVEN;
            end
            FIN_B: begin
                bus.s_rd   = 1'b1;
                bus.s_addr = '0;
                state_nxt  = FIN_A;
            end
            FIN_A:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            i        <= '0;
            bus.pt_a <= '0;
            bus.pt_b <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    a <= bus.ct_a;
                    b <= bus.ct_b;
                    i <= T_LEN'(R);
                end
                EVEN: b <= b_even;
                ODD: begin
                    a <= a_odd;
                    i <= i - T_LEN'(1);
                end
                FIN_B: b <= b - bus.s_data;
                FIN_A: begin
                    bus.pt_a <= a - bus.s_data;
                    bus.pt_b <= b;
                end
                default: ;
            endcase
        end
    end
endmodule
